// File: rtl/scic_pkg.sv
// Shared definitions for the single-cycle-instruction CPU: opcodes, instruction
// field positions and the fetch-stage state encoding.
package scic_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SL  = 4'h2;
  localparam logic [3:0] OP_SR  = 4'h3;
  localparam logic [3:0] OP_LI  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_BR  = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;

  localparam int unsigned OPCODE_MSB  = 31;
  localparam int unsigned OPCODE_LSB  = 28;
  localparam int unsigned OPERAND_MSB = 15;
  localparam int unsigned OPERAND_LSB = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StDecode = 2'd2,
    StIssue  = 2'd3
  } fetch_state_e;

  // Opcodes handed to the execute stage; NOP and BR are resolved in fetch.
  function automatic logic is_issuable(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_ST) || (op == OP_AND);
  endfunction

  function automatic logic is_undefined(input logic [3:0] op);
    return op >= 4'hA;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch/decode front end: owns the PC, reads the instruction ROM, resolves NOP/BR
// locally and issues everything else to the execute stage over valid/ready.
module instruction_fetch
  import scic_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 5,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_cs,
  input  logic [31:0]       rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        opcode,
  output logic [15:0]       operand,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [3:0]        ir_op_q;
  logic [15:0]       ir_operand_q;
  logic              rom_cs_q;
  logic              valid_q;
  logic              illegal_q;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_target;

  // Natural overflow of the ADDR_W-wide add gives the modulo-2^ADDR_W wrap.
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign br_target = ir_operand_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      ir_op_q      <= '0;
      ir_operand_q <= '0;
      rom_cs_q     <= 1'b0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q  <= StFetch;
            rom_cs_q <= 1'b1;
          end
        end
        StFetch: begin
          ir_op_q      <= rom_data[OPCODE_MSB:OPCODE_LSB];
          ir_operand_q <= rom_data[OPERAND_MSB:OPERAND_LSB];
          rom_cs_q     <= 1'b0;
          state_q      <= StDecode;
        end
        StDecode: begin
          if (is_issuable(ir_op_q)) begin
            state_q <= StIssue;
            valid_q <= 1'b1;
          end else begin
            // NOP, BR and undefined opcodes retire here without reaching execute.
            pc_q      <= (ir_op_q == OP_BR) ? br_target : pc_inc;
            illegal_q <= is_undefined(ir_op_q);
            state_q   <= run ? StFetch : StIdle;
            rom_cs_q  <= run;
          end
        end
        StIssue: begin
          if (instr_ready) begin
            pc_q     <= pc_inc;
            valid_q  <= 1'b0;
            state_q  <= run ? StFetch : StIdle;
            rom_cs_q <= run;
          end
        end
        default: begin
          state_q  <= StIdle;
          rom_cs_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_address = pc_q;
  assign pc          = pc_q;
  assign rom_cs      = rom_cs_q;
  assign instr_valid = valid_q;
  assign opcode      = ir_op_q;
  assign operand     = ir_operand_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: ROM model, issue scoreboard and
// per-scenario directed checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [4:0]  rom_address;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [15:0] operand;
  logic [4:0]  pc;
  logic        illegal;

  logic [31:0] rom [32];

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] opnd;
    logic [4:0]  pc;
  } issue_t;

  issue_t exp_q[$];
  int     tests = 0;
  int     fails = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_address];

  instruction_fetch #(
    .ADDR_W   (5),
    .RESET_PC (5'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .rom_address (rom_address),
    .rom_cs      (rom_cs),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .pc          (pc),
    .illegal     (illegal)
  );

  // Scoreboard: every handshake must match the next expected issue.
  always @(negedge clk) begin
    issue_t e;
    if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got op=%h opnd=%h pc=%h, required no issue",
                 opcode, operand, pc);
      end else begin
        e = exp_q.pop_front();
        if ({opcode, operand, pc} !== e) begin
          fails++;
          $display("FAIL issue_data: got op=%h opnd=%h pc=%h, required op=%h opnd=%h pc=%h",
                   opcode, operand, pc, e.op, e.opnd, e.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    run         = 1'b0;
    instr_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    clear_rom();
    run = 1'b0;
    instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if ({rom_cs, instr_valid, illegal, pc, opcode, operand} !== 28'h0) begin
      fails++;
      $display("FAIL reset_state: got cs=%b v=%b ill=%b pc=%h op=%h opnd=%h, required all 0",
               rom_cs, instr_valid, illegal, pc, opcode, operand);
    end
    tick();
    tests++;
    if (rom_cs !== 1'b0 || pc !== 5'd0) begin
      fails++;
      $display("FAIL idle_hold: got cs=%b pc=%h, required cs=0 pc=0", rom_cs, pc);
    end
  endtask

  task automatic test_basic_issue();
    clear_rom();
    rom[0] = 32'h4000_000f;
    do_reset();
    instr_ready = 1'b1;
    run = 1'b1;
    exp_q.push_back('{op: 4'h4, opnd: 16'h000f, pc: 5'd0});
    tick();
    tests++;
    if (rom_cs !== 1'b1 || rom_address !== 5'd0) begin
      fails++;
      $display("FAIL basic_fetch: got cs=%b addr=%h, required cs=1 addr=0", rom_cs, rom_address);
    end
    tick();
    run = 1'b0;
    tests++;
    if (rom_cs !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_decode: got cs=%b v=%b, required cs=0 v=0", rom_cs, instr_valid);
    end
    tick();
    tests++;
    if (instr_valid !== 1'b1 || opcode !== 4'h4 || operand !== 16'h000f) begin
      fails++;
      $display("FAIL basic_issue: got v=%b op=%h opnd=%h, required v=1 op=4 opnd=000f",
               instr_valid, opcode, operand);
    end
    tick();
    tests++;
    if (pc !== 5'd1 || instr_valid !== 1'b0 || rom_cs !== 1'b0) begin
      fails++;
      $display("FAIL basic_retire: got pc=%h v=%b cs=%b, required pc=01 v=0 cs=0",
               pc, instr_valid, rom_cs);
    end
    drain();
  endtask

  task automatic test_stall_and_park();
    clear_rom();
    rom[0] = 32'h1000_1234;
    do_reset();
    instr_ready = 1'b0;
    run = 1'b1;
    exp_q.push_back('{op: 4'h1, opnd: 16'h1234, pc: 5'd0});
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) run = 1'b0;
      tests++;
      if (instr_valid !== 1'b1 || opcode !== 4'h1 || operand !== 16'h1234 || pc !== 5'd0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got v=%b op=%h opnd=%h pc=%h, required v=1 op=1 opnd=1234 pc=00",
                 i, instr_valid, opcode, operand, pc);
      end
      tick();
    end
    instr_ready = 1'b1;
    tests++;
    if (instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_sixth: got v=%b, required v=1", instr_valid);
    end
    tick();
    tests++;
    if (instr_valid !== 1'b0 || pc !== 5'd1 || rom_cs !== 1'b0) begin
      fails++;
      $display("FAIL park_after_issue: got v=%b pc=%h cs=%b, required v=0 pc=01 cs=0",
               instr_valid, pc, rom_cs);
    end
    tick();
    tests++;
    if (rom_cs !== 1'b0 || pc !== 5'd1) begin
      fails++;
      $display("FAIL park_idle: got cs=%b pc=%h, required cs=0 pc=01", rom_cs, pc);
    end
    drain();
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0]    = 32'h8000_ffd5;
    rom[5'h15] = 32'h8000_0000;
    do_reset();
    instr_ready = 1'b1;
    run = 1'b1;
    repeat (3) tick();
    tests++;
    if (pc !== 5'h15 || rom_cs !== 1'b1) begin
      fails++;
      $display("FAIL br_upper_ignored: got pc=%h cs=%b, required pc=15 cs=1", pc, rom_cs);
    end
    repeat (2) tick();
    tests++;
    if (pc !== 5'h00 || rom_cs !== 1'b1) begin
      fails++;
      $display("FAIL br_to_zero: got pc=%h cs=%b, required pc=00 cs=1", pc, rom_cs);
    end
    drain();

    clear_rom();
    rom[0] = 32'h8000_0003;
    rom[3] = 32'h8000_0003;
    do_reset();
    run = 1'b1;
    repeat (2) tick();
    for (int c = 3; c <= 10; c++) begin
      tick();
      tests++;
      if (pc !== 5'd3 || rom_cs !== logic'(c % 2)) begin
        fails++;
        $display("FAIL br_tight_loop[c%0d]: got pc=%h cs=%b, required pc=03 cs=%0d",
                 c, pc, rom_cs, c % 2);
      end
    end
    drain();
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[0]  = 32'h8000_001f;
    rom[31] = 32'h9000_00aa;
    do_reset();
    instr_ready = 1'b1;
    run = 1'b1;
    exp_q.push_back('{op: 4'h9, opnd: 16'h00aa, pc: 5'd31});
    repeat (5) tick();
    tests++;
    if (instr_valid !== 1'b1 || pc !== 5'd31) begin
      fails++;
      $display("FAIL wrap_issue: got v=%b pc=%h, required v=1 pc=1f", instr_valid, pc);
    end
    tick();
    tests++;
    if (pc !== 5'd0 || rom_address !== 5'd0 || rom_cs !== 1'b1) begin
      fails++;
      $display("FAIL wrap_fetch: got pc=%h addr=%h cs=%b, required pc=00 addr=00 cs=1",
               pc, rom_address, rom_cs);
    end
    drain();
  endtask

  task automatic test_nop_illegal();
    int exp_pc [8] = '{0, 0, 1, 1, 2, 2, 2, 2};
    int pulses = 0;
    clear_rom();
    rom[0] = 32'h0000_1111;
    rom[1] = 32'hb000_2222;
    rom[2] = 32'h8000_0002;
    do_reset();
    instr_ready = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (illegal === 1'b1) pulses++;
      tests++;
      if (pc !== 5'(exp_pc[c]) || illegal !== (c == 4) || instr_valid !== 1'b0) begin
        fails++;
        $display("FAIL nop_illegal[c%0d]: got pc=%h ill=%b v=%b, required pc=%0d ill=%0d v=0",
                 c + 1, pc, illegal, instr_valid, exp_pc[c], (c == 4));
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL illegal_pulse_count: got %0d, required 1", pulses);
    end
    drain();
  endtask

  task automatic test_reset_in_issue();
    clear_rom();
    rom[2] = 32'h5000_0007;
    rom[0] = 32'h8000_0002;
    do_reset();
    instr_ready = 1'b0;
    run = 1'b1;
    repeat (5) tick();
    tests++;
    if (instr_valid !== 1'b1 || pc !== 5'd2) begin
      fails++;
      $display("FAIL pre_reset_issue: got v=%b pc=%h, required v=1 pc=02", instr_valid, pc);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || pc !== 5'd0 || rom_cs !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_issue: got v=%b pc=%h cs=%b, required v=0 pc=00 cs=0",
               instr_valid, pc, rom_cs);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    clear_rom();
    rom[0] = 32'h1000_0001;
    rom[1] = 32'h2000_0002;
    rom[2] = 32'h0000_0000;
    rom[3] = 32'h6000_0003;
    rom[4] = 32'h8000_0004;
    do_reset();
    instr_ready = 1'b1;
    exp_q.push_back('{op: 4'h1, opnd: 16'h0001, pc: 5'd0});
    exp_q.push_back('{op: 4'h2, opnd: 16'h0002, pc: 5'd1});
    exp_q.push_back('{op: 4'h6, opnd: 16'h0003, pc: 5'd3});
    run = 1'b1;
    while (exp_q.size() != 0 && cnt < 40) begin
      tick();
      cnt++;
    end
    tests++;
    if (cnt != 12) begin
      fails++;
      $display("FAIL b2b_cycles: got %0d cycles (pending %0d), required 12", cnt, exp_q.size());
    end
    tests++;
    if (pc !== 5'd4 || rom_cs !== 1'b1) begin
      fails++;
      $display("FAIL b2b_final_pc: got pc=%h cs=%b, required pc=04 cs=1", pc, rom_cs);
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    instr_ready = 1'b0;
    clear_rom();
    test_reset();
    test_basic_issue();
    test_stall_and_park();
    test_branch();
    test_pc_wrap();
    test_nop_illegal();
    test_reset_in_issue();
    test_back_to_back();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch/decode front end of the single-cycle-instruction CPU. It sits directly downstream of the 32-entry instruction ROM: it owns the program counter, drives the ROM address and chip select, and latches the returned word into an instruction register. It resolves NOP and BR locally and issues every other instruction (opcode + operand) to the execute/accumulator stage over a valid/ready handshake.

Parameters:
ADDR_W, 5, ROM address width; PC wraps modulo 2^ADDR_W
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  fetch enable; 0 parks the block in IDLE at the next instruction boundary
rom_address  output  ADDR_W  address to ROM, equals pc
rom_cs  output  1  ROM chip select, high only in FETCH
rom_data  input  32  instruction word from ROM (combinational from address)
instr_valid  output  1  issued instruction valid, high only in ISSUE
instr_ready  input  1  execute stage accepts instruction
opcode  output  4  IR[31:28], held stable while instr_valid
operand  output  16  IR[15:0], held stable while instr_valid
pc  output  ADDR_W  current program counter
illegal  output  1  one-cycle pulse when an undefined opcode is skipped

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, pc=RESET_PC, IR=0, rom_cs=0, instr_valid=0, illegal=0. Reset overrides everything, including an ISSUE in progress; instr_valid is low the cycle after reset.
- rom_address is always equal to pc (combinational).
- State machine (registered state):
  - IDLE: rom_cs=0. If run=1 -> FETCH, else stay.
  - FETCH: rom_cs=1. IR <= rom_data at the closing edge. -> DECODE.
  - DECODE: classify IR[31:28]:
    - 0x0 (NOP): pc <= pc+1 -> FETCH (or IDLE if run=0).
    - 0x8 (BR): pc <= IR[ADDR_W-1:0]; upper operand bits ignored -> FETCH/IDLE as above.
    - 0xA-0xF (undefined): treat as NOP, illegal=1 for this one cycle, pc <= pc+1.
    - 0x1-0x7, 0x9: -> ISSUE, pc unchanged.
  - ISSUE: instr_valid=1, opcode/operand driven from IR. On an edge with instr_valid & instr_ready: pc <= pc+1; -> FETCH if run=1, else IDLE. Without ready: hold state, IR and outputs unchanged.
- Throughput: 3 cycles per issued instruction with ready tied high. 2 cycles for NOP, BR and illegal.
- run is sampled only at the FETCH/DECODE/ISSUE exit boundaries listed above. Deasserting run never aborts an ISSUE.
- PC arithmetic is modulo 2^ADDR_W: 31+1 wraps to 0. BR to the current pc is a legal tight loop of FETCH/DECODE forever.
- The instruction issue does not depend on instr_ready being high in the same cycle instr_valid rises. Ready may be high early. valid never drops without a handshake except on reset.
- illegal is registered, is a single-cycle pulse, and is 0 at all other times.

Decomposition:
- Shared package scic_pkg: opcode localparams (OP_NOP=0, OP_ADD=1, OP_SL=2, OP_SR=3, OP_LI=4, OP_LD=5, OP_OR=6, OP_ST=7, OP_BR=8, OP_AND=9), the field positions (opcode [31:28], operand [15:0]), and the state encoding for IDLE/FETCH/DECODE/ISSUE.
- No sub-module is needed. PC, IR and the FSM fit in one module. The ROM is instantiated beside this block in the CPU top level, not inside it.

Test Plan:
- Reset then run=1, ready=1, ROM word 0x4000_000f at address 0 -> cycle 1 rom_cs=1, rom_address=0. Cycle 3 instr_valid=1, opcode=4, operand=0x000f. Next cycle pc=1.
- ISSUE with ready=0 for 5 cycles, then 1 -> instr_valid held for 6 cycles, opcode/operand stable, pc increments exactly once.
- ROM word 0x8000_0000 at address 0x15 -> never issued, pc goes 0x15 -> 0x00 two cycles after FETCH. Also BR 0x0003 loops pc at 3.
- pc=31 holding a non-branch word, issued and accepted -> pc wraps to 0 and the next FETCH has rom_address=0.
- Opcode 0x0 and opcode 0xB words -> no instr_valid. illegal pulses once only for 0xB, and pc advances by 1 in each case.
- Assert reset during ISSUE with ready=0 -> instr_valid=0 and pc=0 the next cycle. Separately, run=0 during ISSUE -> the handshake completes and the block parks in IDLE with rom_cs=0.
